oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Sprite OAM DMA engine on the CPU bus, directly downstream of the 2A03 CPU wrapper.
- Watches the CPU's ADDR, DATA_OUT and RW_n outputs for a write to the DMA register ($4014).
- On a hit, pauses the CPU through the wrapper's pause/Rdy path, takes the bus, and copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAM data port ($2004).
- The bus arbiter muxes DMA_* over the CPU bus whenever BUS_GRANT=1.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
CPU_CE  input  1  CPU cycle enable (same pulse driving the CPU ENABLE); all state advances only when CPU_CE=1
CPU_ADDR  input  16  CPU address bus
CPU_DATA_OUT  input  8  CPU write data
CPU_RW_n  input  1  CPU read/write, 1=read
DMA_DATA_IN  input  8  read data returned by the bus for DMA_ADDR, valid on the CE of a READ cycle
CPU_PAUSE  output  1  halts the CPU (drives pause/Rdy)
BUS_GRANT  output  1  DMA owns the bus this CPU cycle
DMA_ADDR  output  16  DMA bus address
DMA_DATA_OUT  output  8  DMA write data
DMA_RW_n  output  1  DMA read/write, 1=read
DMA_DONE  output  1  one-CLK pulse after the final OAM write

Behaviour:
- Parity bit PAR: toggles on every CPU_CE; reset value 0. A cycle is "even" when PAR=0 during its CE.
- States:
  - IDLE
  - HALT: one dummy cycle
  - ALIGN: optional dummy cycle
  - READ
  - WRITE
- Registers: PAGE[7:0], IDX[7:0], BYTE[7:0]. All reset to 0.
- Trigger: in IDLE, on a CE with CPU_ADDR==DMA_REG_ADDR and CPU_RW_n==0, do PAGE<=CPU_DATA_OUT, IDX<=0, state<=HALT.
- State transitions (all on CE only):
  - HALT: next cycle PAR is ~PAR_now. If that is 0, go to READ; otherwise go to ALIGN.
  - ALIGN -> READ.
  - READ: BYTE<=DMA_DATA_IN, then go to WRITE.
  - WRITE: if IDX==255, go to IDLE and pulse DMA_DONE. Otherwise IDX<=IDX+1 (8-bit) and go to READ.
- READs therefore always fall on even cycles and WRITEs on odd cycles.
- Total stall is 513 CPU cycles when HALT is odd and 514 when HALT is even.
- Outputs are registered and decoded from the current state:
  - CPU_PAUSE = (state != IDLE). It rises the CLK after the trigger CE and falls the CLK after the final WRITE CE.
  - BUS_GRANT = 1 in READ and WRITE only.
  - READ: DMA_ADDR={PAGE,IDX}, DMA_RW_n=1.
  - WRITE: DMA_ADDR=OAM_DATA_ADDR, DMA_RW_n=0, DMA_DATA_OUT=BYTE.
  - IDLE/HALT/ALIGN: DMA_ADDR=0, DMA_RW_n=1, DMA_DATA_OUT=0.
- Reset value of every output is 0, except DMA_RW_n which is 1.
- Without CPU_CE, state, PAR and outputs hold; DMA_DONE stays low.
- Writes to DMA_REG_ADDR outside IDLE are ignored; DMA is not restartable mid-transfer.
- CPU reads of $4014 never trigger.
- PAGE=$FF: source addresses $FF00-$FFFF; no wrap into page $00.
- IDX wrap at 255 terminates the transfer; no 257th access.
- RESET asserted mid-transfer: immediately IDLE, CPU_PAUSE=0, BUS_GRANT=0, PAR=0, no DMA_DONE.
- A trigger on the same CE that RESET deasserts is not required to be captured.

Test Plan:
- PAR=1 at trigger, write $02 to $4014 -> HALT on even cycle, ALIGN, first READ addr $0200; CPU_PAUSE high exactly 514 CEs; DMA_DONE pulses once.
- Trigger with PAR=0 (HALT on odd cycle) -> no ALIGN; CPU_PAUSE high exactly 513 CEs.
- Preload $0300+i = i^8'hA5, DMA page $03 -> 256 writes to $2004 with data i^$A5 in order i=0..255, DMA_RW_n=0 only on those writes.
- CPU_CE asserted every 3rd CLK -> identical access sequence; state and outputs hold between CEs; CPU_PAUSE width = 514 or 513 CEs.
- CPU read of $4014, and write to $4015 -> no trigger, CPU_PAUSE stays 0; write $4014 while active (forced) -> ignored, transfer completes unchanged.
- RESET asserted after 100 writes -> outputs return to reset values asynchronously, no DMA_DONE; new $4014 write then runs a full 256-byte transfer from IDX 0.

Source files
------------

// File: rtl/oam_dma_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_controller_if
// Description : CPU-bus signals observed by the sprite OAM DMA engine and the
//               DMA-side bus signals it drives. The master modport is the DMA
//               engine; the slave modport is the CPU wrapper / bus side.
// Revision    : 1.0 - initial release
// ============================================================================
interface oam_dma_controller_if;
    // CPU side, observed by the DMA engine
    logic        CPU_CE;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_OUT;
    logic        CPU_RW_n;
    // Read data returned by the bus for DMA_ADDR
    logic [7:0]  DMA_DATA_IN;
    // DMA engine outputs
    logic        CPU_PAUSE;
    logic        BUS_GRANT;
    logic [15:0] DMA_ADDR;
    logic [7:0]  DMA_DATA_OUT;
    logic        DMA_RW_n;
    logic        DMA_DONE;

    modport master (
        input  CPU_CE, CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, DMA_DATA_IN,
        output CPU_PAUSE, BUS_GRANT, DMA_ADDR, DMA_DATA_OUT, DMA_RW_n, DMA_DONE
    );

    modport slave (
        output CPU_CE, CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, DMA_DATA_IN,
        input  CPU_PAUSE, BUS_GRANT, DMA_ADDR, DMA_DATA_OUT, DMA_RW_n, DMA_DONE
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_controller
// Description : Sprite OAM DMA engine. A CPU write to DMA_REG_ADDR pauses the
//               CPU, then copies 256 bytes from page {PAGE,00..FF} to the OAM
//               data port, alternating even-cycle READs and odd-cycle WRITEs.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    oam_dma_controller_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        par_q, par_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  byte_q, byte_d;

    logic        pause_q, pause_d;
    logic        grant_q, grant_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        rw_n_q, rw_n_d;
    logic        done_q, done_d;

    // Next-state logic: everything advances only on a CPU cycle enable.
    always_comb begin
        state_d = state_q;
        par_d   = par_q;
        page_d  = page_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        done_d  = 1'b0;
        if (bus.CPU_CE) begin
            par_d = ~par_q;
            case (state_q)
                S_IDLE: begin
                    if ((bus.CPU_ADDR == DMA_REG_ADDR) && !bus.CPU_RW_n) begin
                        page_d  = bus.CPU_DATA_OUT;
                        idx_d   = 8'h00;
                        state_d = S_HALT;
                    end
                end
                // Parity during the next cycle is ~par_q; READ must land on
                // an even cycle, so insert ALIGN when the next one is odd.
                S_HALT:  state_d = par_q ? S_READ : S_ALIGN;
                S_ALIGN: state_d = S_READ;
                S_READ: begin
                    byte_d  = bus.DMA_DATA_IN;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    if (idx_q == 8'hFF) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_READ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track it.
    always_comb begin
        pause_d = (state_d != S_IDLE);
        grant_d = 1'b0;
        addr_d  = 16'h0000;
        dout_d  = 8'h00;
        rw_n_d  = 1'b1;
        case (state_d)
            S_READ: begin
                grant_d = 1'b1;
                addr_d  = {page_d, idx_d};
            end
            S_WRITE: begin
                grant_d = 1'b1;
                addr_d  = OAM_DATA_ADDR;
                rw_n_d  = 1'b0;
                dout_d  = byte_d;
            end
            default: ;
        endcase
    end

    // State, data registers and registered outputs; reset clears a transfer at once.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            par_q   <= 1'b0;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            byte_q  <= 8'h00;
            pause_q <= 1'b0;
            grant_q <= 1'b0;
            addr_q  <= 16'h0000;
            dout_q  <= 8'h00;
            rw_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            par_q   <= par_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            pause_q <= pause_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rw_n_q  <= rw_n_d;
            done_q  <= done_d;
        end
    end

    assign bus.CPU_PAUSE    = pause_q;
    assign bus.BUS_GRANT    = grant_q;
    assign bus.DMA_ADDR     = addr_q;
    assign bus.DMA_DATA_OUT = dout_q;
    assign bus.DMA_RW_n     = rw_n_q;
    assign bus.DMA_DONE     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_oam_dma_controller
// Description : Self-checking bench for oam_dma_controller. A cycle-indexed
//               transfer model predicts every output each clock; directed
//               scenarios add literal expectations on widths and addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    oam_dma_controller_if bus();

    logic [7:0] mem [0:65535];
    assign bus.DMA_DATA_IN = mem[bus.DMA_ADDR];

    oam_dma_controller #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) u_dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transfer model: cycle j=1 is HALT, j=2 is ALIGN when needed, then
    // access n=j-2-align alternates READ (even n) / WRITE (odd n) of byte n/2.
    // ------------------------------------------------------------------
    bit          m_busy  = 0;
    bit          m_par   = 0;
    bit          m_align = 0;
    bit          m_done  = 0;
    int          m_j     = 0;
    logic [7:0]  m_page  = 8'h00;
    int          m_n;
    logic        e_grant, e_rw;
    logic [15:0] e_addr;
    logic [7:0]  e_data;

    // Per-clock model update and compare, sampled 1ns after the active edge.
    always @(posedge clk) begin
        #1;
        m_done = 0;
        if (rst) begin
            m_busy = 0;
            m_par  = 0;
        end else if (bus.CPU_CE) begin
            m_par = ~m_par;
            if (m_busy) begin
                m_j++;
                if (m_j > 513 + int'(m_align)) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (bus.CPU_ADDR == 16'h4014 && !bus.CPU_RW_n) begin
                m_busy  = 1;
                m_j     = 1;
                m_page  = bus.CPU_DATA_OUT;
                m_align = (m_par == 1'b0);
            end
        end
        e_grant = 1'b0; e_addr = 16'h0000; e_rw = 1'b1; e_data = 8'h00;
        if (m_busy) begin
            m_n = m_j - 2 - int'(m_align);
            if (m_n >= 0) begin
                e_grant = 1'b1;
                if (m_n % 2 == 0) begin
                    e_addr = {m_page, m_n[8:1]};
                end else begin
                    e_addr = 16'h2004;
                    e_rw   = 1'b0;
                    e_data = mem[{m_page, m_n[8:1]}];
                end
            end
        end
        chk("cyc_pause", bus.CPU_PAUSE, m_busy);
        chk("cyc_grant", bus.BUS_GRANT, e_grant);
        chk("cyc_addr",  bus.DMA_ADDR,  e_addr);
        chk("cyc_rw_n",  bus.DMA_RW_n,  e_rw);
        chk("cyc_done",  bus.DMA_DONE,  m_done);
        if (!e_grant || !e_rw) chk("cyc_data", bus.DMA_DATA_OUT, e_data);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change only on the falling edge)
    // ------------------------------------------------------------------
    int ce_div = 1;
    int ce_cnt = 0;

    task automatic step();
        @(negedge clk);
        ce_cnt++;
        bus.CPU_CE = (ce_cnt % ce_div == 0);
    endtask

    // One CPU bus access on a CE; want_par selects the parity of that CE (-1: any).
    task automatic cpu_access(input logic [15:0] a, input logic [7:0] d,
                              input logic rw, input int want_par);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!(bus.CPU_CE && (want_par < 0 || int'(m_par) == want_par)) && guard < 20);
        bus.CPU_ADDR     = a;
        bus.CPU_DATA_OUT = d;
        bus.CPU_RW_n     = rw;
        step();
        bus.CPU_ADDR     = 16'h0000;
        bus.CPU_DATA_OUT = 8'h00;
        bus.CPU_RW_n     = 1'b1;
    endtask

    int          pcnt, dones, nrd, nwr;
    logic [15:0] first_rd, last_rd;
    logic [7:0]  first_wd, last_wd;

    // Follow a transfer to its end, measuring pause width and accesses.
    task automatic run_xfer(input int inject_at, input int abort_at);
        int  steps = 0;
        bit  seen  = 0;
        pcnt = 0; dones = 0; nrd = 0; nwr = 0;
        first_rd = 16'h0000; last_rd = 16'h0000; first_wd = 8'h00; last_wd = 8'h00;
        while (steps < 4000) begin
            if (bus.DMA_DONE) dones++;
            if (bus.CPU_PAUSE) seen = 1;
            if (bus.CPU_CE && bus.CPU_PAUSE) pcnt++;
            if (bus.CPU_CE && bus.BUS_GRANT && bus.DMA_RW_n) begin
                if (nrd == 0) first_rd = bus.DMA_ADDR;
                last_rd = bus.DMA_ADDR;
                nrd++;
            end
            if (bus.CPU_CE && bus.BUS_GRANT && !bus.DMA_RW_n) begin
                if (nwr == 0) first_wd = bus.DMA_DATA_OUT;
                last_wd = bus.DMA_DATA_OUT;
                nwr++;
                if (nwr == abort_at) begin
                    #2 rst = 1'b1;
                    #1;
                    chk("async_pause", bus.CPU_PAUSE, 1'b0);
                    chk("async_grant", bus.BUS_GRANT, 1'b0);
                    chk("async_addr",  bus.DMA_ADDR,  16'h0000);
                    chk("async_rw_n",  bus.DMA_RW_n,  1'b1);
                    chk("async_done",  bus.DMA_DONE,  1'b0);
                    @(negedge clk);
                    rst = 1'b0;
                    repeat (6) begin
                        step();
                        if (bus.DMA_DONE) dones++;
                    end
                    return;
                end
            end
            if (seen && !bus.CPU_PAUSE) break;
            step();
            steps++;
            if (steps == inject_at) begin
                bus.CPU_ADDR = 16'h4014; bus.CPU_DATA_OUT = 8'h77; bus.CPU_RW_n = 1'b0;
            end else if (inject_at > 0 && steps == inject_at + 1) begin
                bus.CPU_ADDR = 16'h0000; bus.CPU_DATA_OUT = 8'h00; bus.CPU_RW_n = 1'b1;
            end
        end
        if (steps >= 4000) chk("xfer_timeout", 1, 0);
        repeat (6) begin
            step();
            if (bus.DMA_DONE) dones++;
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = a[7:0] ^ (a[15:8] + 8'h3C);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = i[7:0] ^ 8'hA5;

        bus.CPU_CE = 1'b0; bus.CPU_ADDR = 16'h0000; bus.CPU_DATA_OUT = 8'h00; bus.CPU_RW_n = 1'b1;

        // Reset state
        @(posedge clk); #1;
        chk("rst_pause", bus.CPU_PAUSE,    1'b0);
        chk("rst_grant", bus.BUS_GRANT,    1'b0);
        chk("rst_addr",  bus.DMA_ADDR,     16'h0000);
        chk("rst_data",  bus.DMA_DATA_OUT, 8'h00);
        chk("rst_rw_n",  bus.DMA_RW_n,     1'b1);
        chk("rst_done",  bus.DMA_DONE,     1'b0);
        @(negedge clk); rst = 1'b0;

        // Trigger on an odd CE: HALT even, ALIGN inserted
        ce_div = 1;
        cpu_access(16'h4014, 8'h02, 1'b0, 1);
        run_xfer(0, 0);
        chk("t1_pause_ces", pcnt, 514);
        chk("t1_dones", dones, 1);
        chk("t1_first_rd", first_rd, 16'h0200);
        chk("t1_last_rd", last_rd, 16'h02FF);
        chk("t1_nwr", nwr, 256);

        // Trigger on an even CE: no ALIGN; known data pattern
        cpu_access(16'h4014, 8'h03, 1'b0, 0);
        run_xfer(0, 0);
        chk("t2_pause_ces", pcnt, 513);
        chk("t2_first_wd", first_wd, 8'hA5);
        chk("t2_last_wd", last_wd, 8'h5A);
        chk("t2_nwr", nwr, 256);
        chk("t2_nrd", nrd, 256);

        // Sparse cycle enable: one CE every 3 clocks
        ce_div = 3;
        cpu_access(16'h4014, 8'h03, 1'b0, 1);
        run_xfer(0, 0);
        chk("t3_pause_ces", pcnt, 514);
        chk("t3_dones", dones, 1);
        chk("t3_first_wd", first_wd, 8'hA5);
        chk("t3_last_wd", last_wd, 8'h5A);
        cpu_access(16'h4014, 8'h03, 1'b0, 0);
        run_xfer(0, 0);
        chk("t3b_pause_ces", pcnt, 513);
        ce_div = 1;

        // Non-triggering accesses
        cpu_access(16'h4014, 8'h02, 1'b1, -1);
        cpu_access(16'h4015, 8'h02, 1'b0, -1);
        repeat (10) step();
        chk("t4_no_trigger", bus.CPU_PAUSE, 1'b0);

        // Write to $4014 during a transfer is ignored
        cpu_access(16'h4014, 8'h04, 1'b0, -1);
        run_xfer(50, 0);
        chk("t5_first_rd", first_rd, 16'h0400);
        chk("t5_last_rd", last_rd, 16'h04FF);
        chk("t5_nrd", nrd, 256);
        chk("t5_dones", dones, 1);

        // Page $FF does not wrap
        cpu_access(16'h4014, 8'hFF, 1'b0, -1);
        run_xfer(0, 0);
        chk("t6_first_rd", first_rd, 16'hFF00);
        chk("t6_last_rd", last_rd, 16'hFFFF);

        // Reset after 100 writes, then a fresh full transfer
        cpu_access(16'h4014, 8'h05, 1'b0, -1);
        run_xfer(0, 100);
        chk("t7_abort_dones", dones, 0);
        chk("t7_abort_nwr", nwr, 100);
        cpu_access(16'h4014, 8'h06, 1'b0, -1);
        run_xfer(0, 0);
        chk("t7_first_rd", first_rd, 16'h0600);
        chk("t7_nrd", nrd, 256);
        chk("t7_nwr", nwr, 256);
        chk("t7_dones", dones, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
